// File: rtl/rcc_div_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// rcc_div_sel_ctrl_if
// Request channel from the register/config side into the divide-select
// sequencer. A new select code is transferred when req_valid && req_ready.
//
// Signals:
//   req_valid  master -> slave   new select request present
//   req_sel    master -> slave   requested divide-select code (SEL_W bits)
//   req_ready  slave  -> master  sequencer idle and able to take a request
// ---------------------------------------------------------------------------
interface rcc_div_sel_ctrl_if #(
    parameter int SEL_W = 4
);
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready
    );
endinterface

// File: rtl/rcc_div_sel_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_div_sel_ctrl
// Owns the divide-select of the RCC 512-way clock divider. Each accepted
// ratio change gates the downstream clock, waits for a divider period
// boundary, applies the new select, lets the divider settle for a number of
// div_en pulses and then ungates, so downstream logic never sees a runt or
// truncated divided period.
//
// Ports:
//   i_clk        source clock, same clock as the divider
//   rst          asynchronous active-high reset
//   req_if       request channel (slave): req_valid / req_sel / req_ready
//   div_en       divider enable pulse, one cycle per divided period
//   div_sel      registered select driven to the divider
//   clk_gate_en  registered enable for the downstream clock gate
//   busy         registered, high in every state except IDLE
//   done         registered one-cycle pulse per completed request
//   timeout_err  sticky, set when ALIGN or SETTLE runs out of time;
//                cleared by the next accepted request
//
// State table:
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a request, clock running
//   DRAIN  | clock gated, letting the gate cell drain for GATE_DLY cycles
//   ALIGN  | waiting for a div_en pulse (divider period boundary)
//   SWITCH | one cycle, new select registered on exit
//   SETTLE | counting SETTLE_PULSES div_en pulses on the new ratio
//   RESUME | one cycle, clock re-enabled and done pulsed
// ---------------------------------------------------------------------------
module rcc_div_sel_ctrl #(
    parameter int               SEL_W         = 4,
    parameter logic [SEL_W-1:0] RESET_SEL     = '0,
    parameter int               GATE_DLY      = 2,
    parameter int               SETTLE_PULSES = 2,
    parameter int               TIMEOUT       = 1024
) (
    input  logic                i_clk,
    input  logic                rst,
    rcc_div_sel_ctrl_if.slave   req_if,
    input  logic                div_en,
    output logic [SEL_W-1:0]    div_sel,
    output logic                clk_gate_en,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT);

    // The timer is a saturating down-counter: loading N and terminating at
    // zero gives exactly N+1 cycles in the state. DRAIN reuses it.
    localparam logic [TMR_W-1:0] TMO_LOAD   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(GATE_DLY - 1);
    localparam logic [2:0]       PCNT_LAST  = 3'(SETTLE_PULSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ALIGN,
        S_SWITCH,
        S_SETTLE,
        S_RESUME
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [TMR_W-1:0]   tmr;
    logic [2:0]         pcnt;
    logic [SEL_W-1:0]   pend_sel;

    logic               accept;
    logic               sel_same;
    logic               tmr_tc;
    logic               pulse_hit;

    logic [SEL_W-1:0]   div_sel_d;
    logic               clk_gate_en_d;
    logic               busy_d;
    logic               done_d;
    logic               timeout_err_d;

    assign req_if.req_ready = (state == S_IDLE);

    assign accept    = req_if.req_valid && (state == S_IDLE);
    // Bit-exact compare: codes that alias to the same ratio are still a change.
    assign sel_same  = (req_if.req_sel == div_sel);
    assign tmr_tc    = (tmr == '0);
    assign pulse_hit = div_en && (pcnt == PCNT_LAST);

    // State register plus the datapath registers that follow it.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tmr         <= '0;
            pcnt        <= '0;
            pend_sel    <= RESET_SEL;
            div_sel     <= RESET_SEL;
            clk_gate_en <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= next_state;
            div_sel     <= div_sel_d;
            clk_gate_en <= clk_gate_en_d;
            busy        <= busy_d;
            done        <= done_d;
            timeout_err <= timeout_err_d;

            case (state)
                S_IDLE: begin
                    if (accept && !sel_same) begin
                        pend_sel <= req_if.req_sel;
                        tmr      <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    // Reload on exit so ALIGN starts with a full timeout.
                    if (tmr_tc) begin
                        tmr <= TMO_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (!tmr_tc) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_SWITCH: begin
                    // div_en here is deliberately ignored: the divider is
                    // still on the old ratio this cycle.
                    tmr  <= TMO_LOAD;
                    pcnt <= '0;
                end
                S_SETTLE: begin
                    if (!tmr_tc) begin
                        tmr <= tmr - 1'b1;
                    end
                    if (div_en) begin
                        pcnt <= pcnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = sel_same ? S_RESUME : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tmr_tc) begin
                    next_state = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // A pulse on the last timer cycle still counts as aligned.
                if (div_en || tmr_tc) begin
                    next_state = S_SWITCH;
                end
            end
            S_SWITCH: begin
                next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (pulse_hit || tmr_tc) begin
                    next_state = S_RESUME;
                end
            end
            S_RESUME: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        div_sel_d     = div_sel;
        clk_gate_en_d = clk_gate_en;
        busy_d        = (next_state != S_IDLE);
        done_d        = 1'b0;
        timeout_err_d = timeout_err;

        if (accept) begin
            timeout_err_d = 1'b0;
            if (!sel_same) begin
                clk_gate_en_d = 1'b0;
            end
        end

        if ((state == S_ALIGN) && !div_en && tmr_tc) begin
            timeout_err_d = 1'b1;
        end

        if ((state == S_SETTLE) && !pulse_hit && tmr_tc) begin
            timeout_err_d = 1'b1;
        end

        if (state == S_SWITCH) begin
            div_sel_d = pend_sel;
        end

        // Entry into RESUME (from IDLE or SETTLE) ungates and flags done
        // for exactly the RESUME cycle.
        if (next_state == S_RESUME) begin
            clk_gate_en_d = 1'b1;
            done_d        = 1'b1;
        end
    end

endmodule

// File: tb/tb_rcc_div_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rcc_div_sel_ctrl
// Directed bench for rcc_div_sel_ctrl with default parameters. Cycle k of a
// sequence is the clock period that ends at edge k, where edge 0 is the
// accepting edge; outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_rcc_div_sel_ctrl;

    logic       clk;
    logic       rst;
    logic       div_en;
    logic [3:0] div_sel;
    logic       clk_gate_en;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    rcc_div_sel_ctrl_if #(.SEL_W(4)) req_if ();

    rcc_div_sel_ctrl dut (
        .i_clk       (clk),
        .rst         (rst),
        .req_if      (req_if),
        .div_en      (div_en),
        .div_sel     (div_sel),
        .clk_gate_en (clk_gate_en),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge (edge 0); returns in cycle 1.
    task automatic send(input logic [3:0] sel);
        chk("send_ready", 32'(req_if.req_ready), 32'd1);
        req_if.req_valid = 1'b1;
        req_if.req_sel   = sel;
        tick();
        req_if.req_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int n_done;

        rst              = 1'b1;
        div_en           = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_sel   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_div_sel", 32'(div_sel), 32'h0);
        chk("rst_gate",    32'(clk_gate_en), 32'd1);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_done",    32'(done), 32'd0);
        chk("rst_err",     32'(timeout_err), 32'd0);
        chk("rst_ready",   32'(req_if.req_ready), 32'd1);
        rst = 1'b0;

        // Idle hold after reset release.
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (div_sel != 4'h0 || clk_gate_en != 1'b1 || req_if.req_ready != 1'b1 || busy != 1'b0)
                bad++;
        end
        chk("idle_hold", 32'(bad), 32'd0);

        // 0000 -> 1001 with div_en tied high.
        div_en = 1'b1;
        send(4'b1001);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("chg_gate_c%0d", k),  32'(clk_gate_en), (k <= 6) ? 32'd0 : 32'd1);
            chk($sformatf("chg_done_c%0d", k),  32'(done),        (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("chg_sel_c%0d", k),   32'(div_sel),     (k >= 5) ? 32'h9 : 32'h0);
            chk($sformatf("chg_busy_c%0d", k),  32'(busy),        (k <= 7) ? 32'd1 : 32'd0);
            chk($sformatf("chg_ready_c%0d", k), 32'(req_if.req_ready), (k >= 8) ? 32'd1 : 32'd0);
            tick();
        end
        chk("chg_err", 32'(timeout_err), 32'd0);

        // Same select again: no gate drop, done on the next cycle.
        send(4'b1001);
        chk("same_done1", 32'(done), 32'd1);
        chk("same_busy1", 32'(busy), 32'd1);
        chk("same_gate1", 32'(clk_gate_en), 32'd1);
        tick();
        chk("same_done2", 32'(done), 32'd0);
        chk("same_busy2", 32'(busy), 32'd0);
        chk("same_sel",   32'(div_sel), 32'h9);

        // Ratio-512 pulses at edges 100, 612, 1124; switch after edge 100.
        div_en = 1'b0;
        send(4'b1000);
        for (int k = 1; k <= 1126; k++) begin
            div_en = (k == 100 || k == 612 || k == 1124);
            if (k == 101) begin
                chk("r512_sel_old", 32'(div_sel), 32'h9);
                chk("r512_gate_sw", 32'(clk_gate_en), 32'd0);
            end
            if (k == 102) chk("r512_sel_new", 32'(div_sel), 32'h8);
            if (k == 613) chk("r512_gate_p1", 32'(clk_gate_en), 32'd0);
            if (k == 1124) begin
                chk("r512_gate_pre", 32'(clk_gate_en), 32'd0);
                chk("r512_done_pre", 32'(done), 32'd0);
            end
            if (k == 1125) begin
                chk("r512_gate", 32'(clk_gate_en), 32'd1);
                chk("r512_done", 32'(done), 32'd1);
                chk("r512_err",  32'(timeout_err), 32'd0);
            end
            if (k == 1126) chk("r512_busy_end", 32'(busy), 32'd0);
            tick();
        end
        div_en = 1'b0;

        // div_en stuck low: ALIGN and SETTLE both time out.
        send(4'b1111);
        for (int k = 1; k <= 2053; k++) begin
            if (k == 1026) chk("tmo_err_pre", 32'(timeout_err), 32'd0);
            if (k == 1027) begin
                chk("tmo_err_align", 32'(timeout_err), 32'd1);
                chk("tmo_sel_old",   32'(div_sel), 32'h8);
            end
            if (k == 1028) chk("tmo_sel_new", 32'(div_sel), 32'hf);
            if (k == 2051) begin
                chk("tmo_done_pre", 32'(done), 32'd0);
                chk("tmo_gate_pre", 32'(clk_gate_en), 32'd0);
            end
            if (k == 2052) begin
                chk("tmo_done", 32'(done), 32'd1);
                chk("tmo_gate", 32'(clk_gate_en), 32'd1);
            end
            if (k == 2053) begin
                chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
                chk("tmo_busy_end",   32'(busy), 32'd0);
            end
            tick();
        end

        // Next accepted request clears the sticky error.
        div_en = 1'b1;
        send(4'b0000);
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) chk("clr_err", 32'(timeout_err), 32'd0);
            if (k == 7) begin
                chk("clr_done", 32'(done), 32'd1);
                chk("clr_sel",  32'(div_sel), 32'h0);
            end
            tick();
        end

        // Reset mid-SETTLE: asynchronous return to reset values, no done.
        send(4'b1100);
        for (int k = 1; k <= 4; k++) tick();
        chk("arst_in_settle", 32'(div_sel), 32'hc);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_sel",   32'(div_sel), 32'h0);
        chk("arst_gate",  32'(clk_gate_en), 32'd1);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_done",  32'(done), 32'd0);
        chk("arst_ready", 32'(req_if.req_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done) n_done++;
        end
        chk("arst_no_done", 32'(n_done), 32'd0);
        chk("arst_sel_end", 32'(div_sel), 32'h0);

        // Request held high while busy is held off, then taken at edge 8.
        chk("hold_ready0", 32'(req_if.req_ready), 32'd1);
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 4'b0011;
        tick();
        req_if.req_sel   = 4'b1010;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 7) chk($sformatf("hold_ready_c%0d", k), 32'(req_if.req_ready), 32'd0);
            if (k == 7) chk("hold_done1", 32'(done), 32'd1);
            if (k == 8) chk("hold_ready_c8", 32'(req_if.req_ready), 32'd1);
            if (k == 9) begin
                chk("hold_busy2", 32'(busy), 32'd1);
                chk("hold_gate2", 32'(clk_gate_en), 32'd0);
                req_if.req_valid = 1'b0;
            end
            if (k == 12) chk("hold_sel_old", 32'(div_sel), 32'h3);
            if (k == 13) chk("hold_sel_new", 32'(div_sel), 32'ha);
            if (k == 14) chk("hold_done_pre", 32'(done), 32'd0);
            if (k == 15) begin
                chk("hold_done2", 32'(done), 32'd1);
                chk("hold_gate_end", 32'(clk_gate_en), 32'd1);
            end
            if (k == 16) chk("hold_busy_end", 32'(busy), 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
